// File: rtl/dbus_pkg.sv
// Shared types and constants for the CPU data-bus interconnect.
// Optional fault capture port set is enabled by DBUS_FAULT_CAPTURE_EN.
package dbus_pkg;

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    localparam logic [1:0] FC_NONE     = 2'b00;
    localparam logic [1:0] FC_UNMAPPED = 2'b01;
    localparam logic [1:0] FC_TIMEOUT  = 2'b10;
    localparam logic [1:0] FC_OVERRUN  = 2'b11;

    function automatic int strb_w(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/dbus_decode.sv
// Address decoder: mask/base match per slave, lowest index wins.
// Unaffected by DBUS_FAULT_CAPTURE_EN.
module dbus_decode
    import dbus_pkg::*;
#(
    parameter int                          N_SLAVES   = 4,
    parameter int                          ADDR_W     = 32,
    parameter int                          IDX_W      = 2,
    parameter logic [N_SLAVES*ADDR_W-1:0]  SLAVE_BASE = '0,
    parameter logic [N_SLAVES*ADDR_W-1:0]  SLAVE_MASK = '0
) (
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_hit,
    output logic [IDX_W-1:0]  o_idx
);

    // Scan downwards so the lowest matching index is the last one written.
    always_comb begin
        o_hit = 1'b0;
        o_idx = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if ((i_addr & SLAVE_MASK[i*ADDR_W +: ADDR_W])
                    == SLAVE_BASE[i*ADDR_W +: ADDR_W]) begin
                o_hit = 1'b1;
                o_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/dbus_interconnect.sv
// CPU data port to N slaves: decode, ready/stall handshake, timeout, fault.
// Define DBUS_FAULT_CAPTURE_EN to add fault_addr/fault_code/fault_clr.
module dbus_interconnect
    import dbus_pkg::*;
#(
    parameter int                          N_SLAVES      = 4,
    parameter int                          ADDR_W        = 32,
    parameter int                          DATA_W        = 32,
    parameter logic [N_SLAVES*ADDR_W-1:0]  SLAVE_BASE    = {32'h2000_0000,
                                                            32'h1000_0000,
                                                            32'h0000_0000,
                                                            32'hffff_0700},
    parameter logic [N_SLAVES*ADDR_W-1:0]  SLAVE_MASK    = {32'hffff_f000,
                                                            32'hffff_0000,
                                                            32'hffff_0000,
                                                            32'hffff_ff00},
    parameter int                          TIMEOUT       = 15,
    parameter logic [DATA_W-1:0]           UNMAPPED_DATA = 32'hfefe_fefe,
    parameter logic [DATA_W-1:0]           TIMEOUT_DATA  = 32'hfdfd_fdfd
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_W/8-1:0]           m_writeb,
    input  logic                          m_read,
    input  logic [ADDR_W-1:0]             m_addr,
    input  logic [DATA_W-1:0]             m_wdata,
    output logic [DATA_W-1:0]             m_rdata,
    output logic                          m_stall,
    output logic [N_SLAVES*DATA_W/8-1:0]  s_writeb,
    output logic [N_SLAVES-1:0]           s_read,
    output logic [ADDR_W-1:0]             s_addr,
    output logic [DATA_W-1:0]             s_wdata,
    input  logic [N_SLAVES*DATA_W-1:0]    s_rdata,
    input  logic [N_SLAVES-1:0]           s_ready,
    output logic                          fault
`ifdef DBUS_FAULT_CAPTURE_EN
    ,
    input  logic                          fault_clr,
    output logic [ADDR_W-1:0]             fault_addr,
    output logic [1:0]                    fault_code
`endif
);

    localparam int         SW    = strb_w(DATA_W);
    localparam int         IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam logic [7:0] TO    = 8'(TIMEOUT);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [7:0]         r_wcnt;
    logic [7:0]         w_wcnt_nxt;
    logic [IDX_W-1:0]   r_cur;
    logic [IDX_W-1:0]   w_cur_nxt;
    logic               r_fault;
    logic               w_fault_ev;
    logic               w_req;
    logic               w_hit;
    logic [IDX_W-1:0]   w_idx;
    logic [IDX_W-1:0]   w_sel;
    logic               w_sel_rdy;
    logic [DATA_W-1:0]  w_sel_rdata;
    logic               w_strobe;

    dbus_decode #(
        .N_SLAVES   (N_SLAVES),
        .ADDR_W     (ADDR_W),
        .IDX_W      (IDX_W),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK)
    ) u_decode (
        .i_addr (m_addr),
        .o_hit  (w_hit),
        .o_idx  (w_idx)
    );

    assign w_req   = m_read | (|m_writeb);
    assign w_sel   = (r_state == WAIT) ? r_cur : w_idx;
    assign s_addr  = m_addr;
    assign s_wdata = m_wdata;
    assign fault   = r_fault;

    always_comb begin
        w_sel_rdy   = 1'b0;
        w_sel_rdata = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (IDX_W'(i) == w_sel) begin
                w_sel_rdy   = s_ready[i];
                w_sel_rdata = s_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wcnt_nxt  = r_wcnt;
        w_cur_nxt   = r_cur;
        w_strobe    = 1'b0;
        w_fault_ev  = 1'b0;
        m_stall     = 1'b0;
        m_rdata     = UNMAPPED_DATA;
        unique case (r_state)
            IDLE: begin
                if (w_req) begin
                    if (!w_hit) begin
                        w_fault_ev = 1'b1;
                    end else begin
                        w_strobe = 1'b1;
                        if (w_sel_rdy) begin
                            m_rdata = w_sel_rdata;
                        end else begin
                            m_stall     = 1'b1;
                            w_state_nxt = WAIT;
                            w_cur_nxt   = w_idx;
                            w_wcnt_nxt  = 8'd1;
                        end
                    end
                end
            end
            WAIT: begin
                if (w_sel_rdy) begin
                    w_strobe    = 1'b1;
                    m_rdata     = w_sel_rdata;
                    w_state_nxt = IDLE;
                    w_wcnt_nxt  = 8'd0;
                end else if (r_wcnt == TO) begin
                    // Abort: strobes drop in the same cycle the CPU is released.
                    m_rdata     = TIMEOUT_DATA;
                    w_fault_ev  = 1'b1;
                    w_state_nxt = IDLE;
                    w_wcnt_nxt  = 8'd0;
                end else begin
                    w_strobe   = 1'b1;
                    m_stall    = 1'b1;
                    w_wcnt_nxt = r_wcnt + 8'd1;
                end
            end
        endcase
        if (rst) begin
            w_strobe = 1'b0;
            m_stall  = 1'b0;
        end
    end

    always_comb begin
        s_writeb = '0;
        s_read   = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (w_strobe && (IDX_W'(i) == w_sel)) begin
                s_writeb[i*SW +: SW] = m_writeb;
                s_read[i]            = m_read;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_wcnt  <= 8'd0;
            r_cur   <= '0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_wcnt  <= w_wcnt_nxt;
            r_cur   <= w_cur_nxt;
            r_fault <= w_fault_ev;
        end
    end

`ifdef DBUS_FAULT_CAPTURE_EN
    logic [ADDR_W-1:0] r_faddr;
    logic [1:0]        r_fcode;
    logic [1:0]        w_fcode_new;

    // Faults raised in IDLE are decode misses; in WAIT they are timeouts.
    assign w_fcode_new = (r_state == WAIT) ? FC_TIMEOUT : FC_UNMAPPED;
    assign fault_addr  = r_faddr;
    assign fault_code  = r_fcode;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_faddr <= '0;
            r_fcode <= FC_NONE;
        end else if (w_fault_ev) begin
            if ((r_fcode == FC_NONE) || fault_clr) begin
                r_faddr <= m_addr;
                r_fcode <= w_fcode_new;
            end else begin
                r_fcode <= FC_OVERRUN;
            end
        end else if (fault_clr) begin
            r_faddr <= '0;
            r_fcode <= FC_NONE;
        end
    end
`endif

endmodule
